// File: rtl/shiftreg_seq_if.sv
// Host-side control bundle for shiftreg_seq: frame request, bit-period
// exponent, write frame, readback frame and status.
interface shiftreg_seq_if #(
  parameter int WIDTH     = 170,
  parameter int DIV_WIDTH = 6
);
  logic                 start;
  logic [DIV_WIDTH-1:0] div;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     data_out;
  logic                 busy;
  logic                 done;

  modport master (output start, div, data_in, input data_out, busy, done);
  modport slave  (input start, div, data_in, output data_out, busy, done);
endinterface

// File: rtl/shiftreg_seq.sv
// Serial shift-register chain sequencer: shifts one WIDTH-bit frame out MSB
// first, captures the readback, then strobes sr_load.
module shiftreg_seq #(
  parameter int WIDTH     = 170,
  parameter int CNT_WIDTH = 8,
  parameter int DIV_WIDTH = 6,
  parameter int MAX_DIV   = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  shiftreg_seq_if.slave    host,
  input  logic             sr_dout,
  output logic             sr_clk,
  output logic             sr_din,
  output logic             sr_load
);

  localparam int TICK_W = MAX_DIV + 1;

  typedef enum logic [2:0] {IDLE, ARM, SHIFT, LOAD, DONE} state_t;

  state_t               state, nstate;
  logic [TICK_W-1:0]    tick, ntick, p_len, half;
  logic [CNT_WIDTH-1:0] bitcnt, nbit;
  logic [DIV_WIDTH-1:0] pexp, div_eff;
  logic [WIDTH-1:0]     shreg, nshreg, capture;
  logic                 start_q, primed, edge_det, last;

  // primed blocks the first cycle after reset so a start held high is not an edge
  assign edge_det = host.start & ~start_q & primed;
  assign p_len    = TICK_W'(1) << pexp;
  assign half     = p_len >> 1;
  assign last     = (tick == p_len - TICK_W'(1));

  always_comb begin
    if (host.div == '0)
      div_eff = DIV_WIDTH'(1);
    else if (host.div > DIV_WIDTH'(MAX_DIV))
      div_eff = DIV_WIDTH'(MAX_DIV);
    else
      div_eff = host.div;
  end

  always_comb begin
    nstate = state;
    ntick  = tick + TICK_W'(1);
    nbit   = bitcnt;
    nshreg = shreg;
    unique case (state)
      IDLE: begin
        ntick = '0;
        if (edge_det) begin
          nstate = ARM;
          nbit   = '0;
          nshreg = host.data_in;
        end
      end
      ARM: begin
        if (last) begin
          nstate = SHIFT;
          ntick  = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          ntick = '0;
          if (bitcnt == CNT_WIDTH'(WIDTH - 1)) begin
            nstate = LOAD;
            nbit   = '0;
          end else begin
            nbit   = bitcnt + CNT_WIDTH'(1);
            nshreg = {shreg[WIDTH-2:0], 1'b0};
          end
        end
      end
      LOAD: begin
        if (last) begin
          nstate = DONE;
          ntick  = '0;
        end
      end
      DONE: begin
        nstate = IDLE;
        ntick  = '0;
      end
      default: begin
        nstate = IDLE;
        ntick  = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick          <= '0;
      bitcnt        <= '0;
      pexp          <= '0;
      shreg         <= '0;
      capture       <= '0;
      start_q       <= 1'b0;
      primed        <= 1'b0;
      sr_clk        <= 1'b1;
      sr_din        <= 1'b0;
      sr_load       <= 1'b0;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      host.data_out <= '0;
    end else begin
      start_q <= host.start;
      primed  <= 1'b1;
      state   <= nstate;
      tick    <= ntick;
      bitcnt  <= nbit;
      shreg   <= nshreg;

      if (state == IDLE && edge_det) begin
        pexp    <= div_eff;
        capture <= '0;
      end else if (state == SHIFT && tick == half) begin
        capture <= {capture[WIDTH-2:0], sr_dout};
      end

      sr_clk    <= (nstate == SHIFT) ? (ntick >= half) : 1'b1;
      sr_din    <= (nstate == ARM || nstate == SHIFT) ? nshreg[WIDTH-1] : 1'b0;
      sr_load   <= (nstate == LOAD);
      host.busy <= (nstate == ARM || nstate == SHIFT || nstate == LOAD);
      host.done <= (nstate == DONE);
      if (nstate == DONE)
        host.data_out <= capture;
    end
  end

endmodule
